// File: rtl/block_collider.sv
// rtl/block_collider.sv - grid scanner testing balls/shots against block RAM cells
module block_collider #(
    parameter int BALL_NUM = 1,
    parameter int SHOT_NUM = 2,
    parameter int ROWS     = 48,
    parameter int COLS     = 32,
    parameter int BLK_W    = 20,
    parameter int BLK_H    = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    scan_en,
    input  logic [BALL_NUM*10-1:0]  i_bx,
    input  logic [BALL_NUM*10-1:0]  i_by,
    input  logic [BALL_NUM-1:0]     b_active,
    input  logic [5:0]              b_radius,
    input  logic [SHOT_NUM*10-1:0]  i_sx,
    input  logic [SHOT_NUM*10-1:0]  i_sy,
    input  logic [SHOT_NUM-1:0]     s_active,
    input  logic [5:0]              s_radius,
    output logic [6:0]              row,
    output logic [6:0]              col,
    input  logic [3:0]              block,
    output logic                    wr_en,
    output logic [6:0]              wr_row,
    output logic [6:0]              wr_col,
    output logic [3:0]              wr_data,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [BALL_NUM-1:0]     d_ball,
    output logic [SHOT_NUM-1:0]     d_shot,
    output logic [BALL_NUM-1:0]     bounce_x,
    output logic [BALL_NUM-1:0]     bounce_y,
    output logic                    destroy,
    output logic [9:0]              d_x,
    output logic [9:0]              d_y,
    output logic                    frame_done
);

    localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);

    logic                s1_valid;
    logic                s1_fresh;
    logic [6:0]          s1_row;
    logic [6:0]          s1_col;
    logic [3:0]          blk_hold;
    logic [3:0]          cur_block;
    logic [10:0]         x0, x1, y0, y1;
    logic [BALL_NUM-1:0] b_hit, b_bnx, b_bny;
    logic [SHOT_NUM-1:0] s_hit;
    logic                any_hit, stall, capture, advance;

    function automatic logic overlap(input logic [10:0] cx, input logic [10:0] cy,
                                     input logic [10:0] r,
                                     input logic [10:0] lx0, input logic [10:0] lx1,
                                     input logic [10:0] ly0, input logic [10:0] ly1);
        return (cx + r >= lx0) && (cx <= lx1 + r) && (cy + r >= ly0) && (cy <= ly1 + r);
    endfunction

    // Row/col move on while a stalled cell waits, so its RAM data is kept locally.
    assign cur_block = s1_fresh ? block : blk_hold;

    assign x0 = 11'(32'(s1_col) * BLK_W);
    assign x1 = x0 + 11'(BLK_W - 1);
    assign y0 = 11'(32'(s1_row) * BLK_H);
    assign y1 = y0 + 11'(BLK_H - 1);

    always_comb begin
        logic [10:0] cx, cy;
        logic        in_x, in_y;
        b_hit = '0;
        b_bnx = '0;
        b_bny = '0;
        s_hit = '0;
        cx    = '0;
        cy    = '0;
        in_x  = 1'b0;
        in_y  = 1'b0;
        for (int i = 0; i < BALL_NUM; i++) begin
            cx       = {1'b0, i_bx[10*i +: 10]};
            cy       = {1'b0, i_by[10*i +: 10]};
            in_x     = (cx >= x0) && (cx <= x1);
            in_y     = (cy >= y0) && (cy <= y1);
            b_hit[i] = b_active[i] && overlap(cx, cy, {5'b0, b_radius}, x0, x1, y0, y1);
            b_bny[i] = b_hit[i] && (in_x || !in_y);
            b_bnx[i] = b_hit[i] && !in_x;
        end
        for (int j = 0; j < SHOT_NUM; j++) begin
            cx       = {1'b0, i_sx[10*j +: 10]};
            cy       = {1'b0, i_sy[10*j +: 10]};
            s_hit[j] = s_active[j] && overlap(cx, cy, {5'b0, s_radius}, x0, x1, y0, y1);
        end
    end

    assign any_hit = s1_valid && (cur_block != 4'd0) && ((|b_hit) || (|s_hit));
    assign stall   = any_hit && ev_valid && !ev_ready;
    assign capture = any_hit && (!ev_valid || ev_ready);
    assign advance = scan_en && !stall;

    assign wr_en      = capture && (cur_block != 4'hF);
    assign wr_row     = wr_en ? s1_row : 7'd0;
    assign wr_col     = wr_en ? s1_col : 7'd0;
    assign wr_data    = wr_en ? cur_block - 4'd1 : 4'd0;
    assign frame_done = s1_valid && !stall && (s1_row == LAST_ROW) && (s1_col == LAST_COL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row      <= '0;
            col      <= '0;
            s1_valid <= 1'b0;
            s1_fresh <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            blk_hold <= '0;
        end else begin
            blk_hold <= cur_block;
            s1_fresh <= advance;
            if (advance) begin
                s1_valid <= 1'b1;
                s1_row   <= row;
                s1_col   <= col;
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? 7'd0 : row + 7'd1;
                end else begin
                    col <= col + 7'd1;
                end
            end else if (!stall) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ev_valid <= 1'b0;
            d_ball   <= '0;
            d_shot   <= '0;
            bounce_x <= '0;
            bounce_y <= '0;
            destroy  <= 1'b0;
            d_x      <= '0;
            d_y      <= '0;
        end else if (capture) begin
            ev_valid <= 1'b1;
            d_ball   <= b_hit;
            d_shot   <= s_hit;
            bounce_x <= b_bnx;
            bounce_y <= b_bny;
            destroy  <= (cur_block == 4'd1);
            d_x      <= 10'(x0 + 11'(BLK_W / 2));
            d_y      <= 10'(y0 + 11'(BLK_H / 2));
        end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

endmodule
